approx_mult_err_monitor: RTL and testbench

//  Synthesizable error-metric accumulator placed directly downstream of an

---
 rtl/approx_mult_err_monitor_pkg.sv | 14 +
 rtl/approx_mult_err_monitor_seq_udiv.sv | 62 ++++++
 rtl/approx_mult_err_monitor.sv | 145 ++++++++++++++
 tb/tb_approx_mult_err_monitor.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mult_err_monitor_pkg.sv
// Shared constants and FSM encoding for the approximate-multiplier error monitor.
package approx_mult_err_monitor_pkg;

    localparam int unsigned SCALE   = 10000;
    localparam int unsigned SCALE_W = 14;

    typedef logic [1:0] stateT;

    localparam stateT StIdle = 2'd0;
    localparam stateT StRun  = 2'd1;
    localparam stateT StDiv  = 2'd2;
    localparam stateT StDone = 2'd3;

endpackage

// File: rtl/approx_mult_err_monitor_seq_udiv.sv
// Restoring unsigned divider, one quotient bit per cycle, DW cycles per division.
module seq_udiv #(
    parameter int unsigned DW = 30,
    parameter int unsigned PW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [PW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient
);
    localparam int unsigned CW = $clog2(DW + 1);

    logic [PW-1:0] remQ;
    logic [DW-1:0] quoQ;
    logic [PW-1:0] divQ;
    logic [CW-1:0] cntQ;
    logic          busyQ;

    logic [PW:0]   remShift;
    logic          ge;
    logic [PW-1:0] remNext;
    logic [DW-1:0] quoNext;

    // The remainder is always below the divisor, so the subtraction result fits in PW bits.
    assign remShift = {remQ, quoQ[DW-1]};
    assign ge       = remShift >= {1'b0, divQ};
    assign remNext  = ge ? (remShift[PW-1:0] - divQ) : remShift[PW-1:0];
    assign quoNext  = {quoQ[DW-2:0], ge};

    // done is combinational: it marks the cycle whose step yields the final quotient.
    assign busy     = busyQ;
    assign done     = busyQ && (cntQ == CW'(1));
    assign quotient = quoNext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remQ  <= '0;
            quoQ  <= '0;
            divQ  <= '0;
            cntQ  <= '0;
            busyQ <= 1'b0;
        end else if (start) begin
            remQ  <= '0;
            quoQ  <= dividend;
            divQ  <= divisor;
            cntQ  <= CW'(DW);
            busyQ <= 1'b1;
        end else if (busyQ) begin
            remQ <= remNext;
            quoQ <= quoNext;
            cntQ <= cntQ - CW'(1);
            if (cntQ == CW'(1)) begin
                busyQ <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/approx_mult_err_monitor.sv
// Streams (a, b, r) samples, compares r against the exact product and accumulates
// error count, error distance, maximum error and scaled relative error.
module approx_mult_err_monitor
    import approx_mult_err_monitor_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned ACC_W = 48
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_a,
    input  logic [W-1:0]       in_b,
    input  logic [2*W-1:0]     in_r,
    input  logic               in_last,
    output logic               busy,
    output logic               done,
    output logic [2*W:0]       err_count,
    output logic [2*W:0]       zero_err,
    output logic [ACC_W-1:0]   ed_sum,
    output logic [2*W-1:0]     max_ed,
    output logic [ACC_W-1:0]   red_sum
);
    localparam int unsigned PW = 2 * W;
    localparam int unsigned DW = PW + SCALE_W;

    stateT            stateQ, stateD;
    logic             lastQ, lastD;
    logic [PW:0]      errCountQ, errCountD;
    logic [PW:0]      zeroErrQ, zeroErrD;
    logic [ACC_W-1:0] edSumQ, edSumD;
    logic [PW-1:0]    maxEdQ, maxEdD;
    logic [ACC_W-1:0] redSumQ, redSumD;

    logic [PW-1:0] exact;
    logic [PW-1:0] diff;
    logic [DW-1:0] dividend;
    logic [DW-1:0] quotient;
    logic          xfer;
    logic          divStart;
    logic          divDone;
    logic          unusedDivBusy;

    assign exact    = PW'(in_a) * PW'(in_b);
    assign diff     = (in_r >= exact) ? (in_r - exact) : (exact - in_r);
    assign dividend = DW'(diff) * DW'(SCALE);
    assign xfer     = in_valid && (stateQ == StRun);
    assign divStart = xfer && (diff != '0) && (exact != '0);

    seq_udiv #(
        .DW (DW),
        .PW (PW)
    ) uDiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (divStart),
        .dividend (dividend),
        .divisor  (exact),
        .busy     (unusedDivBusy),
        .done     (divDone),
        .quotient (quotient)
    );

    always_comb begin
        stateD    = stateQ;
        lastD     = lastQ;
        errCountD = errCountQ;
        zeroErrD  = zeroErrQ;
        edSumD    = edSumQ;
        maxEdD    = maxEdQ;
        redSumD   = redSumQ;
        case (stateQ)
            StIdle, StDone: begin
                if (start) begin
                    errCountD = '0;
                    zeroErrD  = '0;
                    edSumD    = '0;
                    maxEdD    = '0;
                    redSumD   = '0;
                    lastD     = 1'b0;
                    stateD    = StRun;
                end
            end
            StRun: begin
                if (xfer) begin
                    if (diff != '0) begin
                        errCountD = errCountQ + 1'b1;
                        edSumD    = edSumQ + ACC_W'(diff);
                        if (diff > maxEdQ) begin
                            maxEdD = diff;
                        end
                        if (exact == '0) begin
                            zeroErrD = zeroErrQ + 1'b1;
                        end
                    end
                    if (divStart) begin
                        lastD  = in_last;
                        stateD = StDiv;
                    end else if (in_last) begin
                        stateD = StDone;
                    end
                end
            end
            StDiv: begin
                if (divDone) begin
                    redSumD = redSumQ + ACC_W'(quotient);
                    stateD  = lastQ ? StDone : StRun;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ    <= StIdle;
            lastQ     <= 1'b0;
            errCountQ <= '0;
            zeroErrQ  <= '0;
            edSumQ    <= '0;
            maxEdQ    <= '0;
            redSumQ   <= '0;
        end else begin
            stateQ    <= stateD;
            lastQ     <= lastD;
            errCountQ <= errCountD;
            zeroErrQ  <= zeroErrD;
            edSumQ    <= edSumD;
            maxEdQ    <= maxEdD;
            redSumQ   <= redSumD;
        end
    end

    assign in_ready  = (stateQ == StRun);
    assign busy      = (stateQ == StRun) || (stateQ == StDiv);
    assign done      = (stateQ == StDone);
    assign err_count = errCountQ;
    assign zero_err  = zeroErrQ;
    assign ed_sum    = edSumQ;
    assign max_ed    = maxEdQ;
    assign red_sum   = redSumQ;

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Self-checking bench: directed single-sample table, hand-written control sequences,
// and randomized/sweep runs checked against an arithmetic reference model.
module tb_approx_mult_err_monitor;

    localparam int W     = 8;
    localparam int PW    = 16;
    localparam int ACC_W = 48;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [PW-1:0]    in_r;
    logic             in_last;
    logic             busy;
    logic             done;
    logic [PW:0]      err_count;
    logic [PW:0]      zero_err;
    logic [ACC_W-1:0] ed_sum;
    logic [PW-1:0]    max_ed;
    logic [ACC_W-1:0] red_sum;

    approx_mult_err_monitor #(
        .W     (W),
        .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_r      (in_r),
        .in_last   (in_last),
        .busy      (busy),
        .done      (done),
        .err_count (err_count),
        .zero_err  (zero_err),
        .ed_sum    (ed_sum),
        .max_ed    (max_ed),
        .red_sum   (red_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nCmp  = 0;
    int nFail = 0;

    // Reference model state: plain arithmetic over the samples of one run.
    longint unsigned mErr, mZero, mEd, mMax, mRed;

    typedef struct {
        logic [7:0]      a;
        logic [7:0]      b;
        logic [15:0]     r;
        longint unsigned err;
        longint unsigned zero;
        longint unsigned ed;
        longint unsigned mx;
        longint unsigned red;
    } vecT;

    vecT vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic modelClear();
        mErr = 0; mZero = 0; mEd = 0; mMax = 0; mRed = 0;
    endtask

    task automatic modelAdd(input logic [7:0] a, input logic [7:0] b, input logic [15:0] r);
        longint unsigned ex, rr, d;
        ex = longint'(a) * longint'(b);
        rr = longint'(r);
        d  = (rr > ex) ? rr - ex : ex - rr;
        if (d != 0) begin
            mErr++;
            mEd += d;
            if (d > mMax) mMax = d;
            if (ex == 0) mZero++;
            else mRed += (d * 10000) / ex;
        end
    endtask

    task automatic checkMetrics(input string tag, input longint unsigned err,
                                input longint unsigned zero, input longint unsigned ed,
                                input longint unsigned mx, input longint unsigned red);
        check({tag, ".err_count"}, 64'(err_count), err);
        check({tag, ".zero_err"}, 64'(zero_err), zero);
        check({tag, ".ed_sum"}, 64'(ed_sum), ed % (64'd1 << ACC_W));
        check({tag, ".max_ed"}, 64'(max_ed), mx);
        check({tag, ".red_sum"}, 64'(red_sum), red % (64'd1 << ACC_W));
    endtask

    task automatic doStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers a sample and holds it until accepted; returns the number of refused cycles.
    task automatic sendSample(input logic [7:0] a, input logic [7:0] b, input logic [15:0] r,
                              input logic last, output int waited);
        @(negedge clk);
        in_a = a; in_b = b; in_r = r; in_last = last; in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            nFail++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        int n;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".done"}, 64'(done), 64'd1);
    endtask

    task automatic runStream(input string tag, input int mode, input int count);
        int w;
        logic [7:0]  a, b;
        logic [15:0] r;
        logic [16:0] tmp;
        modelClear();
        doStart();
        for (int i = 0; i < count; i++) begin
            if (mode == 4) begin
                a = (i < 256) ? 8'd1 : (i < 512) ? 8'd3 : (i < 768) ? 8'h55 : 8'd255;
                b = 8'(i);
                r = 16'(a) * 16'(b) - 16'(a & b & 8'd1);
            end else begin
                a = 8'($urandom);
                b = 8'($urandom);
                if ($urandom_range(0, 9) == 0) a = 8'd0;
                case ($urandom_range(0, 3))
                    0: r = 16'(a) * 16'(b);
                    1: r = 16'(a) * 16'(b) - 16'(a & b & 8'd1);
                    2: r = 16'($urandom);
                    default: begin
                        tmp = 17'(16'(a) * 16'(b)) + 17'($urandom_range(0, 300));
                        r = tmp[15:0];
                    end
                endcase
            end
            modelAdd(a, b, r);
            sendSample(a, b, r, (i == count - 1), w);
        end
        waitDone(tag);
        checkMetrics(tag, mErr, mZero, mEd, mMax, mRed);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        in_a = '0; in_b = '0; in_r = '0; in_last = 1'b0;

        vecs[0] = '{8'd12,  8'd10,  16'd120,   0, 0, 0,     0,     0};
        vecs[1] = '{8'd12,  8'd10,  16'd110,   1, 0, 10,    10,    833};
        vecs[2] = '{8'd0,   8'd5,   16'd4,     1, 1, 4,     4,     0};
        vecs[3] = '{8'd255, 8'd255, 16'd0,     1, 0, 65025, 65025, 10000};
        vecs[4] = '{8'd1,   8'd1,   16'd0,     1, 0, 1,     1,     10000};
        vecs[5] = '{8'd255, 8'd255, 16'd65535, 1, 0, 510,   510,   78};
        vecs[6] = '{8'd7,   8'd0,   16'd0,     0, 0, 0,     0,     0};
        vecs[7] = '{8'd200, 8'd3,   16'd601,   1, 0, 1,     1,     16};

        repeat (3) @(negedge clk);
        check("reset.in_ready", 64'(in_ready), 64'd0);
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        checkMetrics("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Directed single-sample runs.
        for (int i = 0; i < 8; i++) begin
            doStart();
            check($sformatf("vec%0d.cleared", i), 64'(err_count), 64'd0);
            sendSample(vecs[i].a, vecs[i].b, vecs[i].r, 1'b1, w);
            waitDone($sformatf("vec%0d", i));
            checkMetrics($sformatf("vec%0d", i), vecs[i].err, vecs[i].zero, vecs[i].ed,
                         vecs[i].mx, vecs[i].red);
        end

        // Exact sample finishes the run on the very next cycle.
        doStart();
        sendSample(8'd12, 8'd10, 16'd120, 1'b1, w);
        check("exact.done_next", 64'(done), 64'd1);

        // Zero exact product: no division, straight to DONE.
        doStart();
        sendSample(8'd0, 8'd5, 16'd4, 1'b1, w);
        check("zero.done_next", 64'(done), 64'd1);
        checkMetrics("zero", 1, 1, 4, 4, 0);

        // Over- then under-estimate; second sample held valid through DIV.
        doStart();
        sendSample(8'd3, 8'd3, 16'd12, 1'b0, w);
        check("seq.err_visible", 64'(err_count), 64'd1);
        check("seq.ed_visible", 64'(ed_sum), 64'd3);
        check("seq.ready_low", 64'(in_ready), 64'd0);
        sendSample(8'd255, 8'd255, 16'd65000, 1'b1, w);
        check("seq.div_cycles", 64'(w), 64'd30);
        waitDone("seq");
        checkMetrics("seq", 2, 0, 28, 25, 3336);

        // Start pulsed while busy is ignored.
        doStart();
        sendSample(8'd12, 8'd10, 16'd110, 1'b0, w);
        doStart();
        check("busystart.busy", 64'(busy), 64'd1);
        sendSample(8'd12, 8'd10, 16'd120, 1'b1, w);
        waitDone("busystart");
        checkMetrics("busystart", 1, 0, 10, 10, 833);

        // Reset in the middle of a division.
        doStart();
        sendSample(8'd12, 8'd10, 16'd110, 1'b0, w);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst.busy", 64'(busy), 64'd0);
        check("midrst.in_ready", 64'(in_ready), 64'd0);
        checkMetrics("midrst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("midrst.idle_busy", 64'(busy), 64'd0);
        check("midrst.idle_done", 64'(done), 64'd0);
        check("midrst.idle_red", 64'(red_sum), 64'd0);

        // Randomized runs and a structured sweep against the model.
        for (int k = 0; k < 3; k++) runStream($sformatf("rand%0d", k), 0, 150);
        runStream("sweep", 4, 1024);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
